// File: rtl/time_set_controller.sv
// Wall-clock timekeeping sequencer: BCD time registers advanced by a 1 Hz prescaler tick,
// with minute/hour set buttons offering single-step on press and auto-repeat while held.
module time_set_controller #(
  parameter int TICK_DIV      = 100_000_000,
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 20_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       MButton,
  input  logic       HButton,
  output logic [5:0] seconds,
  output logic [3:0] mins1,
  output logic [3:0] mins2,
  output logic [3:0] hours1,
  output logic [3:0] hours2,
  output logic       sec_tick,
  output logic       blink
);

  localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF  = PW'(TICK_DIV / 2);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, M_HOLD, M_RPT, H_HOLD, H_RPT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          min_issue, hrs_issue;
  logic          min_inc_q, hrs_inc_q;
  logic          is_min, own_btn;

  logic [PW-1:0] prescaler, pre_n;
  logic          pending, pend_n, tick_n, raw_tick;
  logic [5:0]    sec_n;
  logic [3:0]    m1_n, m2_n, h1_n, h2_n;
  logic [3:0]    m1_inc, m2_inc, h1_inc, h2_inc;
  logic          m_wrap, h_wrap;

  assign raw_tick = (prescaler == PRE_LAST);
  assign blink    = (prescaler < PRE_HALF);
  assign is_min   = (state == M_HOLD) || (state == M_RPT);
  assign own_btn  = is_min ? MButton : HButton;

  // Only the button that started the sequence is watched until the FSM is back in IDLE.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    min_issue = 1'b0;
    hrs_issue = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (MButton) begin
          state_n   = M_HOLD;
          min_issue = 1'b1;
        end else if (HButton) begin
          state_n   = H_HOLD;
          hrs_issue = 1'b1;
        end
      end
      M_HOLD, H_HOLD: begin
        if (!own_btn) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_n                = is_min ? M_RPT : H_RPT;
          cnt_n                  = '0;
          {min_issue, hrs_issue} = is_min ? 2'b10 : 2'b01;
        end
      end
      M_RPT, H_RPT: begin
        if (!own_btn) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == RPT_LAST) begin
          cnt_n                  = '0;
          {min_issue, hrs_issue} = is_min ? 2'b10 : 2'b01;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Incremented BCD values, shared by button increments and tick carries.
  always_comb begin
    m_wrap = (mins2 == 4'd5) && (mins1 == 4'd9);
    m1_inc = (mins1 == 4'd9) ? 4'd0 : mins1 + 4'd1;
    m2_inc = (mins1 != 4'd9) ? mins2 : (m_wrap ? 4'd0 : mins2 + 4'd1);
    h_wrap = (hours2 == 4'd2) && (hours1 == 4'd3);
    h1_inc = (h_wrap || hours1 == 4'd9) ? 4'd0 : hours1 + 4'd1;
    h2_inc = h_wrap ? 4'd0 : ((hours1 == 4'd9) ? hours2 + 4'd1 : hours2);
  end

  // One update source per cycle: minute-set > hour-set > tick. A tick colliding with
  // hour-set is deferred one cycle; one colliding with minute-set is dropped.
  always_comb begin
    sec_n  = seconds;
    m1_n   = mins1;
    m2_n   = mins2;
    h1_n   = hours1;
    h2_n   = hours2;
    pre_n  = raw_tick ? '0 : prescaler + 1'b1;
    pend_n = pending;
    tick_n = 1'b0;
    if (min_inc_q) begin
      sec_n  = '0;
      pre_n  = '0;
      pend_n = 1'b0;
      m1_n   = m1_inc;
      m2_n   = m2_inc;
    end else if (hrs_inc_q) begin
      h1_n   = h1_inc;
      h2_n   = h2_inc;
      pend_n = pending | raw_tick;
    end else if (pending || raw_tick) begin
      tick_n = 1'b1;
      pend_n = 1'b0;
      if (seconds == 6'd59) begin
        sec_n = '0;
        m1_n  = m1_inc;
        m2_n  = m2_inc;
        if (m_wrap) begin
          h1_n = h1_inc;
          h2_n = h2_inc;
        end
      end else begin
        sec_n = seconds + 6'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      min_inc_q <= 1'b0;
      hrs_inc_q <= 1'b0;
      prescaler <= '0;
      pending   <= 1'b0;
      sec_tick  <= 1'b0;
      seconds   <= '0;
      mins1     <= '0;
      mins2     <= '0;
      hours1    <= '0;
      hours2    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      min_inc_q <= min_issue;
      hrs_inc_q <= hrs_issue;
      prescaler <= pre_n;
      pending   <= pend_n;
      sec_tick  <= tick_n;
      seconds   <= sec_n;
      mins1     <= m1_n;
      mins2     <= m2_n;
      hours1    <= h1_n;
      hours2    <= h2_n;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: stimulus queues cycle-stamped expected outputs,
// a negedge monitor pops and compares entries whose cycle has arrived.
module tb_time_set_controller;

  localparam int TD = 10;
  localparam int HD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mb  = 1'b0;
  logic       hb  = 1'b0;
  logic [5:0] seconds;
  logic [3:0] mins1, mins2, hours1, hours2;
  logic       sec_tick, blink;

  time_set_controller #(
    .TICK_DIV(TD), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK100MHZ(clk), .Reset(rst), .MButton(mb), .HButton(hb),
    .seconds(seconds), .mins1(mins1), .mins2(mins2),
    .hours1(hours1), .hours2(hours2), .sec_tick(sec_tick), .blink(blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [23:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Packed as {hours2,hours1,mins2,mins1,seconds,sec_tick,blink}.
  function automatic logic [23:0] pack(int h, int m, int s, logic t, logic b);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 6'(s), t, b};
  endfunction

  task automatic expect_at(input int at, input int h, input int m, input int s,
                           input logic t, input logic b, input string tag);
    exp_t e;
    e.at  = at;
    e.exp = pack(h, m, s, t, b);
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [23:0] act;
    act = {hours2, hours1, mins2, mins1, seconds, sec_tick, blink};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, {8'h0, act}, {8'h0, sb[i].exp});
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: missed, got nothing required %h", sb[i].tag, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int base);
    step(1);
    rst = 1'b1;
    expect_at(cyc + 1, 0, 0, 0, 1'b0, 1'b1, "reset_state");
    step(2);
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic press(input logic is_min, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_min) mb = 1'b1; else hb = 1'b1;
      step(1);
      mb = 1'b0;
      hb = 1'b0;
      step(1);
    end
  endtask

  int r;

  initial begin
    // Free run: 60 ticks, 10 cycles apart.
    do_reset(r);
    for (int k = 1; k <= 60; k++) begin
      expect_at(r + 10 * k, 0, k / 60, k % 60, 1'b1, 1'b1, $sformatf("run_tick%0d", k));
      expect_at(r + 10 * k + 5, 0, k / 60, k % 60, 1'b0, 1'b0, $sformatf("run_mid%0d", k));
    end
    step(605);

    // Preload 23:59:58 and roll over; hour presses collide with ticks (deferred).
    do_reset(r);
    expect_at(r + 10, 5, 0, 0, 1'b0, 1'b1, "hrs_tick_collide");
    expect_at(r + 11, 5, 0, 1, 1'b1, 1'b1, "pending_tick");
    expect_at(r + 46, 23, 0, 4, 1'b0, 1'b0, "hours_23");
    expect_at(r + 164, 23, 59, 0, 1'b0, 1'b1, "mins_59");
    expect_at(r + 744, 23, 59, 58, 1'b1, 1'b1, "preload_58");
    expect_at(r + 763, 23, 59, 59, 1'b0, 1'b0, "preload_59");
    expect_at(r + 764, 0, 0, 0, 1'b1, 1'b1, "day_wrap");
    press(1'b0, 23);
    press(1'b1, 59);
    step(601);

    // Minute press at 12:59:37 wraps minutes without carry, clears seconds and prescaler.
    do_reset(r);
    expect_at(r + 24, 12, 0, 2, 1'b0, 1'b1, "hours_12");
    expect_at(r + 142, 12, 59, 0, 1'b0, 1'b1, "mins_59b");
    expect_at(r + 512, 12, 59, 37, 1'b1, 1'b1, "at_12_59_37");
    expect_at(r + 514, 12, 0, 0, 1'b0, 1'b1, "min_wrap_no_carry");
    expect_at(r + 519, 12, 0, 0, 1'b0, 1'b0, "prescaler_restart");
    expect_at(r + 524, 12, 0, 1, 1'b1, 1'b1, "first_tick_after_set");
    press(1'b0, 12);
    press(1'b1, 59);
    step(370);
    mb = 1'b1;
    step(1);
    mb = 1'b0;
    step(12);

    // Hour button held 20 cycles: press, hold-delay repeat, then every 4 cycles.
    do_reset(r);
    expect_at(r + 2, 1, 0, 0, 1'b0, 1'b1, "hold_inc1");
    expect_at(r + 10, 2, 0, 0, 1'b0, 1'b1, "hold_inc2");
    expect_at(r + 11, 2, 0, 1, 1'b1, 1'b1, "hold_pending");
    expect_at(r + 14, 3, 0, 1, 1'b0, 1'b1, "rpt_inc3");
    expect_at(r + 18, 4, 0, 1, 1'b0, 1'b0, "rpt_inc4");
    expect_at(r + 30, 4, 0, 3, 1'b1, 1'b1, "hold_final");
    hb = 1'b1;
    step(20);
    hb = 1'b0;
    step(11);

    // Hour increment coincides with a raw tick at 05:10:59.
    do_reset(r);
    expect_at(r + 10, 5, 0, 0, 1'b0, 1'b1, "hours_5");
    expect_at(r + 30, 5, 10, 0, 1'b0, 1'b1, "mins_10");
    expect_at(r + 620, 5, 10, 59, 1'b1, 1'b1, "at_05_10_59");
    expect_at(r + 629, 5, 10, 59, 1'b0, 1'b0, "before_collide");
    expect_at(r + 630, 6, 10, 59, 1'b0, 1'b1, "hrs_wins");
    expect_at(r + 631, 6, 11, 0, 1'b1, 1'b1, "deferred_tick");
    expect_at(r + 632, 6, 11, 0, 1'b0, 1'b1, "single_sec_tick");
    expect_at(r + 640, 6, 11, 1, 1'b1, 1'b1, "tick_cadence_kept");
    press(1'b0, 5);
    press(1'b1, 10);
    step(598);
    hb = 1'b1;
    step(1);
    hb = 1'b0;
    step(12);

    // Both buttons together, then reset during minute auto-repeat with button still held.
    do_reset(r);
    expect_at(r + 2, 0, 1, 0, 1'b0, 1'b1, "both_minutes_win");
    expect_at(r + 4, 0, 1, 0, 1'b0, 1'b1, "both_no_hours");
    expect_at(r + 6, 0, 2, 0, 1'b0, 1'b1, "m_press");
    expect_at(r + 14, 0, 3, 0, 1'b0, 1'b1, "m_repeat1");
    expect_at(r + 18, 0, 4, 0, 1'b0, 1'b1, "m_repeat2");
    mb = 1'b1;
    hb = 1'b1;
    step(1);
    mb = 1'b0;
    hb = 1'b0;
    step(3);
    mb = 1'b1;
    step(14);
    do_reset(r);
    expect_at(r + 2, 0, 1, 0, 1'b0, 1'b1, "held_after_reset");
    expect_at(r + 6, 0, 1, 0, 1'b0, 1'b1, "fsm_idle_after_reset");
    expect_at(r + 12, 0, 1, 1, 1'b1, 1'b1, "tick_after_reset");
    step(1);
    mb = 1'b0;
    step(14);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
